// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO with a valid/ready handshake.
// Configurable baud divider, optional even/odd parity, 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int SH_W   = DATA_W + 1;

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 1 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_fifo: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop, empty;
    logic [DATA_W-1:0] head;
    logic              par_bit;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [SH_W-1:0]   shreg, shreg_n;
    logic              tx_n, bit_done, load;

    // ---------------- FIFO ----------------
    assign empty    = (fifo_count == '0);
    assign tx_ready = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push     = tx_valid && tx_ready;
    assign pop      = load;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        case (PARITY)
            1:       par_bit = ^head;
            2:       par_bit = ~^head;
            default: par_bit = 1'b0;
        endcase
    end

    // ---------------- serialiser FSM ----------------
    assign bit_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx_busy  = (state != S_IDLE) || !empty;

    // The parity bit rides above the data in the shift register, so after
    // DATA_W shifts it lands in bit 0 ready for the PAR field.
    always_comb begin
        state_n = state;
        baud_n  = bit_done ? '0 : baud_cnt + BAUD_W'(1);
        bit_n   = bit_cnt;
        shreg_n = shreg;
        tx_n    = tx;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (!empty) load = 1'b1;
            end
            S_START: if (bit_done) begin
                state_n = S_DATA;
                tx_n    = shreg[0];
                shreg_n = shreg >> 1;
                bit_n   = '0;
            end
            S_DATA: if (bit_done) begin
                if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                    bit_n = '0;
                    if (PARITY != 0) begin
                        state_n = S_PAR;
                        tx_n    = shreg[0];
                    end else begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end
                end else begin
                    bit_n   = bit_cnt + BIT_W'(1);
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                end
            end
            S_PAR: if (bit_done) begin
                state_n = S_STOP;
                tx_n    = 1'b1;
                bit_n   = '0;
            end
            S_STOP: if (bit_done) begin
                if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                    bit_n = '0;
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    bit_n = bit_cnt + BIT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Popping from IDLE or from the last stop bit both start a new frame.
        if (load) begin
            state_n = S_START;
            tx_n    = 1'b0;
            shreg_n = {par_bit, head};
            baud_n  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances cover even parity with a
// 4-cycle bit, odd parity with a 2-cycle bit, and no parity / 2 stop bits.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v0, v1, v2;
    logic [7:0] d0, d1, d2;
    logic       r0, r1, r2;
    logic       tx0, tx1, tx2;
    logic       b0, b1, b2;
    logic [2:0] c0, c1, c2;

    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0), .tx_ready(r0),
        .tx(tx0), .tx_busy(b0), .fifo_count(c0));
    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1), .tx_ready(r1),
        .tx(tx1), .tx_busy(b1), .fifo_count(c1));
    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2), .tx_ready(r2),
        .tx(tx2), .tx_busy(b2), .fifo_count(c2));

    int n_chk = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int w);
        case (w)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       return b0;
            1:       return b1;
            default: return b2;
        endcase
    endfunction

    // bits[i] is the i-th serial bit of the frame; checks cycles first..end,
    // ticking after each, so it returns sampled just after the frame's last edge.
    task automatic expect_bits(input int w, input string tag, input logic [15:0] bits,
                               input int nbits, input int cpb, input int first);
        for (int c = first; c < nbits * cpb; c++) begin
            chk($sformatf("%s_tx_c%0d", tag, c), 32'(tx_of(w)), 32'(bits[4'(c / cpb)]));
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy_of(w)), 32'd1);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        d0 = '0;   d1 = '0;   d2 = '0;
        tick();
        tick();
        chk("rst_tx",    32'(tx0), 32'd1);
        chk("rst_busy",  32'(b0),  32'd0);
        chk("rst_count", 32'(c0),  32'd0);
        chk("rst_ready", 32'(r0),  32'd0);
        chk("rst_tx2",   32'(tx2), 32'd1);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(r0), 32'd1);

        // 1: 0xA5 even parity -> parity 0, 44-cycle frame, start one edge after accept
        v0 = 1'b1; d0 = 8'hA5;
        tick();
        v0 = 1'b0;
        chk("t1_accept_count", 32'(c0), 32'd1);
        chk("t1_accept_tx",    32'(tx0), 32'd1);
        chk("t1_accept_busy",  32'(b0), 32'd1);
        tick();
        expect_bits(0, "t1", 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 4, 0);
        chk("t1_end_busy",  32'(b0), 32'd0);
        chk("t1_end_tx",    32'(tx0), 32'd1);
        chk("t1_end_count", 32'(c0), 32'd0);

        // 2: odd parity, 0x00 -> 1, 0x01 -> 0
        v1 = 1'b1; d1 = 8'h00;
        tick();
        d1 = 8'h01;
        tick();
        v1 = 1'b0;
        expect_bits(1, "t2a", 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11, 2, 0);
        expect_bits(1, "t2b", 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11, 2, 0);
        chk("t2_end_busy", 32'(b1), 32'd0);

        // 3: valid held high with 6 words into a 4-deep FIFO
        v0 = 1'b1; d0 = 8'h01;
        tick();
        chk("t3_e0_count", 32'(c0), 32'd1);
        d0 = 8'h03;
        tick();
        chk("t3_e1_count", 32'(c0), 32'd1);
        chk("t3_e1_tx",    32'(tx0), 32'd0);
        d0 = 8'h07;
        tick();
        chk("t3_e2_count", 32'(c0), 32'd2);
        d0 = 8'h80;
        tick();
        chk("t3_e3_count", 32'(c0), 32'd3);
        d0 = 8'hFE;
        tick();
        chk("t3_full_count", 32'(c0), 32'd4);
        chk("t3_full_ready", 32'(r0), 32'd0);
        d0 = 8'h5A;
        expect_bits(0, "t3w0", 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 4, 3);
        chk("t3_pop_count", 32'(c0), 32'd3);
        chk("t3_pop_ready", 32'(r0), 32'd1);
        chk("t3_pop_tx",    32'(tx0), 32'd0);
        tick();
        v0 = 1'b0;
        chk("t3_w5_count", 32'(c0), 32'd4);
        expect_bits(0, "t3w1", 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 4, 1);
        expect_bits(0, "t3w2", 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 4, 0);
        expect_bits(0, "t3w3", 16'({1'b1, 1'b1, 8'h80, 1'b0}), 11, 4, 0);
        expect_bits(0, "t3w4", 16'({1'b1, 1'b1, 8'hFE, 1'b0}), 11, 4, 0);
        expect_bits(0, "t3w5", 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, 4, 0);
        chk("t3_end_busy", 32'(b0), 32'd0);
        chk("t3_end_tx",   32'(tx0), 32'd1);

        // 4: two queued words go out back to back with busy held high
        v0 = 1'b1; d0 = 8'h3C;
        tick();
        d0 = 8'hC1;
        tick();
        v0 = 1'b0;
        expect_bits(0, "t4a", 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 4, 0);
        expect_bits(0, "t4b", 16'({1'b1, 1'b1, 8'hC1, 1'b0}), 11, 4, 0);
        chk("t4_end_busy", 32'(b0), 32'd0);

        // 6: no parity, 2 stop bits, 1-cycle bits; push+pop at count=1
        v2 = 1'b1; d2 = 8'h96;
        tick();
        chk("t6_e0_count", 32'(c2), 32'd1);
        d2 = 8'h4B;
        tick();
        v2 = 1'b0;
        chk("t6_pushpop_count", 32'(c2), 32'd1);
        expect_bits(2, "t6a", 16'({2'b11, 8'h96, 1'b0}), 11, 1, 0);
        expect_bits(2, "t6b", 16'({2'b11, 8'h4B, 1'b0}), 11, 1, 0);
        chk("t6_end_busy", 32'(b2), 32'd0);
        chk("t6_end_tx",   32'(tx2), 32'd1);

        // 5: reset during data bit 3 with two words queued
        v0 = 1'b1; d0 = 8'hF7;
        tick();
        d0 = 8'h12;
        tick();
        d0 = 8'h34;
        tick();
        v0 = 1'b0;
        chk("t5_queued", 32'(c0), 32'd2);
        for (int i = 0; i < 15; i++) tick();
        chk("t5_d3_tx", 32'(tx0), 32'd0);
        rst = 1'b1;
        tick();
        chk("t5_rst_tx",    32'(tx0), 32'd1);
        chk("t5_rst_count", 32'(c0), 32'd0);
        chk("t5_rst_busy",  32'(b0), 32'd0);
        chk("t5_rst_ready", 32'(r0), 32'd0);
        rst = 1'b0;
        tick();
        chk("t5_post_ready", 32'(r0), 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t5_quiet_tx_%0d", i), 32'(tx0), 32'd1);
            tick();
        end
        chk("t5_quiet_busy",  32'(b0), 32'd0);
        chk("t5_quiet_count", 32'(c0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
